// File: rtl/menu_char_overlay.sv
// rtl/menu_char_overlay.sv - menu text overlay: text/font ROM addressing and glyph compositing
// Four-cycle feed-forward pipeline; every output lags its input by exactly four clocks.
module menu_char_overlay #(
   parameter logic [10:0] XPOS     = 11'd256,
   parameter logic [10:0] YPOS     = 11'd128,
   parameter logic [11:0] FG_COLOR = 12'hFFF,
   parameter logic        BG_EN    = 1'b0,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   output logic [3:0]  char_line,
   input  logic [7:0]  char_pixels,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam logic [10:0] XEND = XPOS + 11'd128;
   localparam logic [10:0] YEND = YPOS + 11'd256;

   // Only the low offset bits are ever used, and those are identical to the full 11-bit difference.
   logic [6:0]  w_dx;
   logic [7:0]  w_dy;
   logic        w_in_box;
   logic        w_glyph_bit;
   logic [11:0] w_rgb_next;

   logic [7:0]  r_char_xy;
   logic [3:0]  r_char_line;
   logic [3:0]  r_dy1;
   logic [2:0]  r_dx1;
   logic [2:0]  r_dx2;
   logic [2:0]  r_dx3;
   logic        r_in_box1;
   logic        r_in_box2;
   logic        r_in_box3;

   logic [3:0][10:0] r_hcount_d;
   logic [3:0][10:0] r_vcount_d;
   logic [3:0][3:0]  r_timing_d;
   logic [2:0][11:0] r_rgb_d;
   logic [11:0]      r_rgb_out;

   assign w_dx = hcount_in[6:0] - XPOS[6:0];
   assign w_dy = vcount_in[7:0] - YPOS[7:0];

   assign w_in_box = (hcount_in >= XPOS) && (hcount_in < XEND) &&
                     (vcount_in >= YPOS) && (vcount_in < YEND) &&
                     !hblnk_in && !vblnk_in;

   // Font slice is MSB-first: column 0 of the cell is bit 7.
   assign w_glyph_bit = char_pixels[3'd7 - r_dx3];

   always_comb begin
      w_rgb_next = r_rgb_d[2];
      if (r_in_box3 && w_glyph_bit) begin
         w_rgb_next = FG_COLOR;
      end else if (r_in_box3 && BG_EN) begin
         w_rgb_next = BG_COLOR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_char_xy   <= '0;
         r_char_line <= '0;
         r_dy1       <= '0;
         r_dx1       <= '0;
         r_dx2       <= '0;
         r_dx3       <= '0;
         r_in_box1   <= 1'b0;
         r_in_box2   <= 1'b0;
         r_in_box3   <= 1'b0;
      end else begin
         r_char_xy   <= w_in_box ? {w_dy[7:4], w_dx[6:3]} : 8'h00;
         r_dy1       <= w_dy[3:0];
         r_dx1       <= w_dx[2:0];
         r_in_box1   <= w_in_box;
         r_char_line <= r_in_box1 ? r_dy1 : 4'h0;
         r_dx2       <= r_dx1;
         r_in_box2   <= r_in_box1;
         r_dx3       <= r_dx2;
         r_in_box3   <= r_in_box2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hcount_d <= '0;
         r_vcount_d <= '0;
         r_timing_d <= '0;
         r_rgb_d    <= '0;
         r_rgb_out  <= '0;
      end else begin
         r_hcount_d <= {r_hcount_d[2:0], hcount_in};
         r_vcount_d <= {r_vcount_d[2:0], vcount_in};
         r_timing_d <= {r_timing_d[2:0], {hsync_in, vsync_in, hblnk_in, vblnk_in}};
         r_rgb_d    <= {r_rgb_d[1:0], rgb_in};
         r_rgb_out  <= w_rgb_next;
      end
   end

   assign char_xy    = r_char_xy;
   assign char_line  = r_char_line;
   assign hcount_out = r_hcount_d[3];
   assign vcount_out = r_vcount_d[3];
   assign hsync_out  = r_timing_d[3][3];
   assign vsync_out  = r_timing_d[3][2];
   assign hblnk_out  = r_timing_d[3][1];
   assign vblnk_out  = r_timing_d[3][0];
   assign rgb_out    = r_rgb_out;

endmodule

// File: doc/menu_char_overlay.md
Name: menu_char_overlay

Overview:
- Text-overlay stage of the menu screen. Takes the VGA timing/pixel stream and computes the character-cell address `char_xy` for the menu text ROM.
- Computes the glyph row index `char_line` for the font ROM, then consumes the returned 8-pixel glyph slice and paints foreground pixels over the incoming RGB.
- Delays all timing signals to match the text-ROM plus font-ROM latency, so the output stream stays pixel-aligned.

Parameters:
- XPOS, 11'd256, left edge of text box in pixels
- YPOS, 11'd128, top edge of text box in pixels
- FG_COLOR, 12'hFFF, glyph pixel colour
- BG_EN, 1'b0, 1 = fill non-glyph box pixels with BG_COLOR; 0 = pass rgb through
- BG_COLOR, 12'h000, box background colour when BG_EN=1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  background pixel colour
- char_xy  out  8  {row[3:0], col[3:0]} address to the text ROM
- char_line  out  4  glyph row to the font ROM, aligned with the text ROM's `char_code`
- char_pixels  in  8  font ROM glyph slice, bit 7 = leftmost pixel
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel

Behaviour:
- Reset: all outputs and all pipeline registers clear to 0 asynchronously on rst_n low. The first update after release is on the next clk rising edge.
- Glyph geometry is fixed:
  - Cells are 8x16 pixels; the grid is 16 cols x 16 rows, so the box is 128x256 pixels.
  - dx = hcount_in - XPOS; dy = vcount_in - YPOS (11-bit, unsigned).
- in_box = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+256) && !hblnk_in && !vblnk_in.
- Stage 1 (cycle T+1):
  - char_xy <= in_box ? {dy[7:4], dx[6:3]} : 8'h00.
  - Register dy[3:0], dx[2:0] and in_box.
- Stage 2 (T+2):
  - char_line <= stage-1 dy[3:0], or 0 if not in_box.
  - The text ROM presents `char_code` for char_xy in this same cycle.
- Stage 3 (T+3): the font ROM (synchronous, 1 cycle) presents char_pixels for {char_code, char_line}.
- Stage 4 (T+4): register rgb_out using bit = char_pixels[7 - dx_d3[2:0]], where dx_d3 and in_box_d3 are dx[2:0] and in_box delayed 3 cycles:
  - in_box_d3 && bit → FG_COLOR
  - in_box_d3 && !bit && BG_EN → BG_COLOR
  - otherwise → rgb_in delayed 4
- All timing outputs and the counters are the inputs delayed by exactly 4 cycles through shift registers. Total latency input→output is 4 clocks for every signal.
- Blanking inside the box geometry: in_box = 0, so rgb passes through unchanged.
- Box edges: pixel XPOS+127 / line YPOS+255 are inside the box; pixel XPOS+128 / line YPOS+256 are outside.
- Counter wrap (hcount 0 after 1055 etc.): no special case. The pipeline is purely feed-forward with no state beyond the delay lines.
- Reset mid-frame: the pipeline flushes to zeros. The outputs show 0 timing/rgb for 4 cycles after release, then track the input.
- Combinational depth: one 11-bit subtract and compare per stage 1. No divider is used; row and column come from bit slicing only.

Test Plan:
- Reset: hold rst_n=0 with active stimulus → all outputs 0. Release → hsync_out equals hsync_in delayed exactly 4 clk.
- Address map:
  - hcount=XPOS+19, vcount=YPOS+37 → char_xy=8'h22 one cycle later, char_line=4'h5 two cycles later.
  - hcount=XPOS+127, vcount=YPOS+255 → char_xy=8'hFF.
- Overlay: use a font model returning 8'b1000_0001 for every address, rgb_in=12'h123, FG_COLOR=12'hFFF.
  - Line YPOS: pixels XPOS and XPOS+7 → rgb_out=FFF.
  - Pixels XPOS+1..XPOS+6 → rgb_out=123.
  - All results appear 4 cycles after the corresponding input.
- Outside box: hcount=XPOS-1 or XPOS+128, any vcount → rgb_out=rgb_in delayed 4 and char_xy=0. Repeat with BG_EN=1, BG_COLOR=12'h00F → box non-glyph pixels = 00F, outside pixels unchanged.
- Blanking: hblnk_in=1 with hcount inside the box range → rgb_out=rgb_in delayed 4, no FG pixel.
- Mid-frame reset: assert rst_n=0 for 3 cycles during an active box line → outputs immediately 0. After release, the first 4 outputs are 0, then the overlay resumes correctly on the following pixels.
